sobel_addr_walker: RTL and testbench

Parametrised raster address generator for the Sobel pipeline. It replaces the fixed 1024-entry counter with an engine sized by image width and height. It has two modes: a linear scan, used for loading and storing frames, and a 3x3 window scan, used for Sobel reads. The window scan emits nine neighbour addresses per centre pixel, replicating the border pixels. It sits between the control FSM (start/busy/done) and the frame RAM read/write ports (addr/valid/ready).

---
 rtl/sobel_addr_walker.sv | 181 ++++++++++++++++++
 tb/tb_sobel_addr_walker.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_addr_walker.sv
// Raster address walker for the Sobel pipeline.
// Emits linear frame addresses or 3x3 clamped-window neighbour addresses.
module sobel_addr_walker #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  output logic [ADDR_W-1:0] center_addr,
  output logic [3:0]        tap,
  output logic              tap_last,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef logic [ADDR_W-1:0] a_t;

  localparam a_t W_A = a_t'(IMG_W);
  localparam a_t WM1 = a_t'(IMG_W - 1);
  localparam a_t HM2 = a_t'(IMG_H - 2);
  localparam a_t NM1 = a_t'(IMG_W * IMG_H - 1);
  localparam a_t ONE = a_t'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LIN,
    S_WIN,
    S_FIN
  } state_t;

  state_t state, n_state;
  a_t x, y, cen, rb_u, rb_c, rb_d;
  a_t n_x, n_y, n_cen, n_rbu, n_rbc, n_rbd;
  a_t n_row, n_xc;
  logic [3:0] t, n_t;
  logic acc;

  assign acc = addr_vld & ready;

  always_comb begin
    n_state = state;
    n_x     = x;
    n_y     = y;
    n_t     = t;
    n_cen   = cen;
    n_rbu   = rb_u;
    n_rbc   = rb_c;
    n_rbd   = rb_d;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          n_state = mode ? S_WIN : S_LIN;
          n_x     = '0;
          n_y     = '0;
          n_t     = '0;
          n_cen   = '0;
          n_rbu   = '0;
          n_rbc   = '0;
          n_rbd   = W_A;
        end
      end
      S_LIN: begin
        if (abort) begin
          n_state = S_IDLE;
        end else if (acc) begin
          if (cen == NM1) n_state = S_FIN;
          else n_cen = cen + ONE;
        end
      end
      S_WIN: begin
        if (abort) begin
          n_state = S_IDLE;
        end else if (acc) begin
          if (t != 4'd8) begin
            n_t = t + 4'd1;
          end else if (cen == NM1) begin
            n_state = S_FIN;
          end else begin
            n_t   = '0;
            n_cen = cen + ONE;
            if (x == WM1) begin
              // Row change: the rows above/below slide down, clamped at the bottom.
              n_x   = '0;
              n_y   = y + ONE;
              n_rbu = rb_c;
              n_rbc = rb_c + W_A;
              if (y < HM2) n_rbd = rb_d + W_A;
            end else begin
              n_x = x + ONE;
            end
          end
        end
      end
      S_FIN: n_state = S_IDLE;
      default: n_state = S_IDLE;
    endcase
  end

  always_comb begin
    n_row = n_rbc;
    unique case (1'b1)
      (n_t < 4'd3): n_row = n_rbu;
      (n_t >= 4'd3 && n_t < 4'd6): n_row = n_rbc;
      default: n_row = n_rbd;
    endcase
  end

  always_comb begin
    n_xc = n_x;
    unique case (n_t)
      4'd0, 4'd3, 4'd6: n_xc = (n_x == '0) ? '0 : n_x - ONE;
      4'd2, 4'd5, 4'd8: n_xc = (n_x == WM1) ? n_x : n_x + ONE;
      default: n_xc = n_x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      x           <= '0;
      y           <= '0;
      t           <= '0;
      cen         <= '0;
      rb_u        <= '0;
      rb_c        <= '0;
      rb_d        <= '0;
      addr        <= '0;
      addr_vld    <= 1'b0;
      center_addr <= '0;
      tap         <= '0;
      tap_last    <= 1'b0;
      last        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state    <= n_state;
      x        <= n_x;
      y        <= n_y;
      t        <= n_t;
      cen      <= n_cen;
      rb_u     <= n_rbu;
      rb_c     <= n_rbc;
      rb_d     <= n_rbd;
      addr_vld <= (n_state == S_LIN) || (n_state == S_WIN);
      busy     <= (n_state == S_LIN) || (n_state == S_WIN);
      done     <= (n_state == S_FIN);
      unique case (n_state)
        S_LIN: begin
          addr        <= n_cen;
          center_addr <= n_cen;
          tap         <= '0;
          tap_last    <= 1'b1;
          last        <= (n_cen == NM1);
        end
        S_WIN: begin
          addr        <= n_row + n_xc;
          center_addr <= n_cen;
          tap         <= n_t;
          tap_last    <= (n_t == 4'd8);
          last        <= (n_cen == NM1) && (n_t == 4'd8);
        end
        default: begin
          addr        <= '0;
          center_addr <= '0;
          tap         <= '0;
          tap_last    <= 1'b0;
          last        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_addr_walker.sv
// Directed bench for sobel_addr_walker.
// Covers 32x32 and 5x3 frames: linear, window, backpressure, abort, reset.
module tb_sobel_addr_walker;

  typedef struct packed {
    logic [9:0]  addr;
    logic [9:0]  cen;
    logic [3:0]  tap;
    logic        tl;
    logic        lst;
    logic [31:0] cyc;
  } beat_t;

  typedef struct {
    int    kind;
    int    idx;
    beat_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start1, start2, mode, abort, ready;

  logic [9:0] a1, c1;
  logic [3:0] t1;
  logic v1, tl1, l1, b1, d1;
  logic [3:0] a2, c2;
  logic [3:0] t2;
  logic v2, tl2, l2, b2, d2;

  bit sel;
  logic [9:0] m_addr, m_cen;
  logic [3:0] m_tap;
  logic m_vld, m_tl, m_last, m_busy, m_done;

  int checks = 0;
  int errors = 0;
  beat_t cap[$];
  vec_t vecs[$];
  int done_cyc;

  always #5 clk = ~clk;

  sobel_addr_walker #(.IMG_W(32), .IMG_H(32), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .abort(abort),
    .ready(ready), .addr(a1), .addr_vld(v1), .center_addr(c1), .tap(t1),
    .tap_last(tl1), .last(l1), .busy(b1), .done(d1)
  );

  sobel_addr_walker #(.IMG_W(5), .IMG_H(3), .ADDR_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .abort(abort),
    .ready(ready), .addr(a2), .addr_vld(v2), .center_addr(c2), .tap(t2),
    .tap_last(tl2), .last(l2), .busy(b2), .done(d2)
  );

  always_comb begin
    m_addr = sel ? {6'd0, a2} : a1;
    m_cen  = sel ? {6'd0, c2} : c1;
    m_tap  = sel ? t2 : t1;
    m_vld  = sel ? v2 : v1;
    m_tl   = sel ? tl2 : tl1;
    m_last = sel ? l2 : l1;
    m_busy = sel ? b2 : b1;
    m_done = sel ? d2 : d1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t model(input bit win, input int w, input int h,
                                  input int i);
    beat_t b;
    int c, t, x, y, xc, yc;
    if (!win) begin
      b.addr = 10'(i);
      b.cen  = 10'(i);
      b.tap  = 4'd0;
      b.tl   = 1'b1;
      b.lst  = (i == w * h - 1);
    end else begin
      c  = i / 9;
      t  = i % 9;
      x  = c % w;
      y  = c / w;
      xc = x + (t % 3) - 1;
      yc = y + (t / 3) - 1;
      if (xc < 0) xc = 0;
      if (xc > w - 1) xc = w - 1;
      if (yc < 0) yc = 0;
      if (yc > h - 1) yc = h - 1;
      b.addr = 10'(yc * w + xc);
      b.cen  = 10'(c);
      b.tap  = 4'(t);
      b.tl   = (t == 8);
      b.lst  = (c == w * h - 1) && (t == 8);
    end
    b.cyc = 32'(i + 1);
    return b;
  endfunction

  task automatic add(input int kind, input int idx, input int a,
                     input int c, input int t, input bit tl, input bit lst);
    vec_t v;
    v.kind     = kind;
    v.idx      = idx;
    v.exp.addr = 10'(a);
    v.exp.cen  = 10'(c);
    v.exp.tap  = 4'(t);
    v.exp.tl   = tl;
    v.exp.lst  = lst;
    v.exp.cyc  = 32'(idx + 1);
    vecs.push_back(v);
  endtask

  task automatic run(input bit win, input int bound);
    int cyc;
    cap.delete();
    done_cyc = -1;
    @(negedge clk);
    mode = win;
    if (sel) start2 = 1'b1;
    else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    mode   = 1'b0;
    cyc    = 1;
    while (done_cyc < 0 && cyc <= bound) begin
      if (m_vld && ready)
        cap.push_back({m_addr, m_cen, m_tap, m_tl, m_last, 32'(cyc)});
      if (m_done) begin
        done_cyc = cyc;
        chk("done_cycle_outputs_zero",
            64'({m_addr, m_cen, m_tap, m_tl, m_last, m_vld, m_busy}), 64'(0));
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen_before_bound", 64'(done_cyc >= 0), 64'(1));
    if (done_cyc >= 0) begin
      @(negedge clk);
      chk("done_one_cycle", 64'({m_done, m_busy, m_vld}), 64'(0));
    end
  endtask

  task automatic check_model(input string nm, input bit win, input int w,
                             input int h);
    int tot, bad, first;
    beat_t e;
    tot   = win ? 9 * w * h : w * h;
    bad   = 0;
    first = -1;
    chk({nm, "_beat_count"}, 64'(cap.size()), 64'(tot));
    foreach (cap[i]) begin
      e = model(win, w, h, i);
      if (cap[i] !== e) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_sequence_first_bad_%0d", nm, first), 64'(bad), 64'(0));
  endtask

  task automatic check_vecs(input int kind);
    foreach (vecs[k]) begin
      if (vecs[k].kind == kind) begin
        if (vecs[k].idx < cap.size())
          chk($sformatf("vec%0d_beat%0d", k, vecs[k].idx),
              64'(cap[vecs[k].idx]), 64'(vecs[k].exp));
        else
          chk($sformatf("vec%0d_beat%0d_missing", k, vecs[k].idx),
              64'(cap.size()), 64'(vecs[k].idx + 1));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0[9], w165[9], w1023[9], p7[9];
    int bad, prev, dsum, maxa;

    w0    = '{0, 0, 1, 0, 0, 1, 32, 32, 33};
    w165  = '{132, 133, 134, 164, 165, 166, 196, 197, 198};
    w1023 = '{990, 991, 991, 1022, 1023, 1023, 1022, 1023, 1023};
    p7    = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
    add(0, 0, 0, 0, 0, 1'b1, 1'b0);
    add(0, 500, 500, 500, 0, 1'b1, 1'b0);
    add(0, 1023, 1023, 1023, 0, 1'b1, 1'b1);
    for (int t = 0; t < 9; t++) begin
      add(1, t, w0[t], 0, t, t == 8, 1'b0);
      add(1, 165 * 9 + t, w165[t], 165, t, t == 8, 1'b0);
      add(1, 1023 * 9 + t, w1023[t], 1023, t, t == 8, t == 8);
      add(2, 7 * 9 + t, p7[t], 7, t, t == 8, 1'b0);
    end

    rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode = 1'b0; abort = 1'b0; ready = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_dut", 64'({a1, v1, c1, t1, tl1, l1, b1, d1}), 64'(0));
    chk("reset_outputs_dut2", 64'({a2, v2, c2, t2, tl2, l2, b2, d2}), 64'(0));
    rst = 1'b1;

    run(1'b0, 1100);
    chk("lin_done_cycle", 64'(done_cyc), 64'(1025));
    check_model("lin", 1'b0, 32, 32);
    check_vecs(0);

    run(1'b1, 9300);
    chk("win_done_cycle", 64'(done_cyc), 64'(9217));
    check_model("win", 1'b1, 32, 32);
    check_vecs(1);

    sel = 1'b1;
    run(1'b1, 200);
    chk("p5x3_done_cycle", 64'(done_cyc), 64'(136));
    check_model("p5x3", 1'b1, 5, 3);
    check_vecs(2);
    maxa = 0;
    foreach (cap[i]) if (int'(cap[i].addr) > maxa) maxa = int'(cap[i].addr);
    chk("p5x3_addr_le_14", 64'(maxa <= 14), 64'(1));
    sel = 1'b0;

    // Backpressure at addr 7, ignored start at 100, abort at 500.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("lin_start_latency", 64'({v1, b1, a1, c1, t1}), 64'({2'b11, 24'd0}));
    for (int k = 0; k < 20 && a1 != 10'd7; k++) @(negedge clk);
    chk("bp_reach_7", 64'(a1), 64'(7));
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_7", 64'({v1, a1, l1}), 64'({1'b1, 10'd7, 1'b0}));
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_next_8", 64'({v1, a1}), 64'({1'b1, 10'd8}));
    prev = 8;
    bad  = 0;
    for (int k = 0; k < 600 && a1 != 10'd500; k++) begin
      start1 = (a1 == 10'd100);
      mode   = (a1 == 10'd100);
      @(negedge clk);
      if (int'(a1) != prev + 1 || t1 != 4'd0 || !v1) bad++;
      prev = int'(a1);
    end
    start1 = 1'b0;
    mode   = 1'b0;
    chk("contig_no_drop_restart", 64'(bad), 64'(0));
    chk("reach_500", 64'(a1), 64'(500));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_outputs", 64'({v1, b1, d1, a1}), 64'(0));
    dsum = 0;
    repeat (4) begin
      @(negedge clk);
      dsum += int'(d1) + int'(b1);
    end
    chk("abort_no_done", 64'(dsum), 64'(0));

    // Reset mid-scan.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 400 && a1 != 10'd300; k++) @(negedge clk);
    chk("reach_300", 64'(a1), 64'(300));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_midscan_outputs", 64'({a1, v1, c1, t1, tl1, l1, b1, d1}), 64'(0));
    rst    = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("restart_addr_0", 64'({v1, b1, a1}), 64'({2'b11, 10'd0}));
    @(negedge clk);
    chk("restart_addr_1", 64'({v1, a1}), 64'({1'b1, 10'd1}));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
